// File: rtl/float_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract: flush-to-zero inputs, round-to-nearest-even, valid/ready flow.
// Stage 1 aligns operands, stage 2 adds and counts leading zeros, stage 3 rounds and selects specials.
module float_addsub_pipe #(
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXPO_WIDTH+MANT_WIDTH:0] op_a,
  input  logic [EXPO_WIDTH+MANT_WIDTH:0] op_b,
  input  logic                           sub,
  input  logic [TAG_WIDTH-1:0]           tag_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXPO_WIDTH+MANT_WIDTH:0] result,
  output logic [3:0]                     flags,
  output logic [TAG_WIDTH-1:0]           tag_out
);
  localparam int EW = EXPO_WIDTH;
  localparam int MW = MANT_WIDTH;
  localparam int DW = 1 + EW + MW;
  localparam int AW = MW + 4;  // hidden bit, mantissa, guard, round, sticky
  localparam int SW = MW + 5;  // AW plus carry
  localparam int LW = $clog2(SW + 1);
  localparam int XW = ((EW > LW) ? EW : LW) + 2;
  localparam logic [EW-1:0] EXP_ONES = '1;
  localparam logic [DW-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

  logic v1, v2, load1, load2, load3;

  assign load3    = !out_valid || out_ready;
  assign load2    = !v2 || load3;
  assign load1    = !v1 || load2;
  assign in_ready = load1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load1) v1 <= in_valid;
      if (load2) v2 <= v1;
      if (load3) out_valid <= v2;
    end
  end

  // ---------------- stage 1: decode and align ----------------
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;
  logic          a_ones, b_ones, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

  assign sa     = op_a[DW-1];
  assign sb     = op_b[DW-1] ^ sub;
  assign ea     = op_a[DW-2:MW];
  assign eb     = op_b[DW-2:MW];
  assign ma     = op_a[MW-1:0];
  assign mb     = op_b[MW-1:0];
  assign a_ones = (ea == EXP_ONES);
  assign b_ones = (eb == EXP_ONES);
  assign a_nan  = a_ones && (ma != '0);
  assign b_nan  = b_ones && (mb != '0);
  assign a_snan = a_nan && !ma[MW-1];
  assign b_snan = b_nan && !mb[MW-1];
  assign a_inf  = a_ones && (ma == '0);
  assign b_inf  = b_ones && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  logic          swap, sign_c, spec_c, nv_c;
  logic [EW-1:0] e_big, e_sml, e_diff;
  logic [MW:0]   sig_a, sig_b;
  logic [AW-1:0] big_c, sml_ext, sml_c;
  logic [DW-1:0] spec_res_c;

  always_comb begin
    sig_a   = a_zero ? '0 : {1'b1, ma};
    sig_b   = b_zero ? '0 : {1'b1, mb};
    swap    = {eb, sig_b} > {ea, sig_a};
    e_big   = swap ? eb : ea;
    e_sml   = swap ? ea : eb;
    sign_c  = swap ? sb : sa;
    big_c   = {(swap ? sig_b : sig_a), 3'b000};
    sml_ext = {(swap ? sig_a : sig_b), 3'b000};
    e_diff  = e_big - e_sml;
    if (int'(e_diff) >= MW + 3)
      sml_c = {{(AW-1){1'b0}}, |sml_ext};
    else
      sml_c = (sml_ext >> e_diff) |
              {{(AW-1){1'b0}}, |(sml_ext & ~({AW{1'b1}} << e_diff))};

    nv_c       = a_snan || b_snan || (a_inf && b_inf && (sa != sb));
    spec_c     = 1'b1;
    spec_res_c = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      spec_res_c = QNAN;
    else if (a_inf)
      spec_res_c = {sa, EXP_ONES, {MW{1'b0}}};
    else if (b_inf)
      spec_res_c = {sb, EXP_ONES, {MW{1'b0}}};
    else if (a_zero && b_zero)
      spec_res_c = {sa && sb, {(DW-1){1'b0}}};  // only -0 plus -0 keeps the sign
    else
      spec_c = 1'b0;
  end

  logic                 s1_special, s1_nv, s1_sign, s1_effsub;
  logic [DW-1:0]        s1_spec_res;
  logic [EW-1:0]        s1_exp;
  logic [AW-1:0]        s1_big, s1_sml;
  logic [TAG_WIDTH-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (load1 && in_valid) begin
      s1_special  <= spec_c;
      s1_nv       <= nv_c;
      s1_spec_res <= spec_res_c;
      s1_sign     <= sign_c;
      s1_effsub   <= (sa != sb);
      s1_exp      <= e_big;
      s1_big      <= big_c;
      s1_sml      <= sml_c;
      s1_tag      <= tag_in;
    end
  end

  // ---------------- stage 2: magnitude add and leading-zero count ----------------
  logic [SW-1:0] sum_c;
  logic [LW-1:0] lz_c;

  always_comb begin
    if (s1_effsub) sum_c = {1'b0, s1_big} - {1'b0, s1_sml};
    else           sum_c = {1'b0, s1_big} + {1'b0, s1_sml};
    lz_c = LW'(SW);
    for (int i = 0; i < SW; i++)
      if (sum_c[i]) lz_c = LW'(SW - 1 - i);
  end

  logic                 s2_special, s2_nv, s2_sign;
  logic [DW-1:0]        s2_spec_res;
  logic [EW-1:0]        s2_exp;
  logic [SW-1:0]        s2_sum;
  logic [LW-1:0]        s2_lz;
  logic [TAG_WIDTH-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (load2 && v1) begin
      s2_special  <= s1_special;
      s2_nv       <= s1_nv;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_c;
      s2_lz       <= lz_c;
      s2_tag      <= s1_tag;
    end
  end

  // ---------------- stage 3: normalise, round, select ----------------
  logic [SW-1:0] norm;
  logic [XW-1:0] exp_n, exp_r;
  logic [MW:0]   rnd;
  logic          g, r, s, inc, nx, uf, of;
  logic [DW-1:0] res_c;
  logic [3:0]    flags_c;

  always_comb begin
    norm  = s2_sum << s2_lz;
    exp_n = XW'(s2_exp) + XW'(1) - XW'(s2_lz);
    g     = norm[3];
    r     = norm[2];
    s     = |norm[1:0];
    inc   = g && (r || s || norm[4]);
    rnd   = {1'b0, norm[MW+3:4]} + {{MW{1'b0}}, inc};
    exp_r = exp_n + {{(XW-1){1'b0}}, rnd[MW]};
    nx    = g || r || s;
    uf    = exp_n[XW-1] || (exp_n == '0);
    of    = !uf && (exp_r >= XW'(EXP_ONES));

    res_c   = {s2_sign, exp_r[EW-1:0], rnd[MW-1:0]};
    flags_c = {3'b000, nx};
    if (s2_special) begin
      res_c   = s2_spec_res;
      flags_c = {s2_nv, 3'b000};
    end else if (!norm[SW-1]) begin
      res_c   = '0;  // exact cancellation
      flags_c = 4'b0000;
    end else if (uf) begin
      res_c   = {s2_sign, {(DW-1){1'b0}}};
      flags_c = 4'b0011;
    end else if (of) begin
      res_c   = {s2_sign, EXP_ONES, {MW{1'b0}}};
      flags_c = 4'b0101;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      flags   <= '0;
      tag_out <= '0;
    end else if (load3 && v2) begin
      result  <= res_c;
      flags   <= flags_c;
      tag_out <= s2_tag;
    end
  end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed bench for float_addsub_pipe: FP32 vectors, stall/reset behaviour and an FP16 build.
module tb_float_addsub_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  flags, tag_in, tag_out;

  logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
  logic [15:0] h_op_a, h_op_b, h_result;
  logic [3:0]  h_flags, h_tag_in, h_tag_out;

  float_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .tag_out(tag_out)
  );

  float_addsub_pipe #(.EXPO_WIDTH(5), .MANT_WIDTH(10), .TAG_WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .op_a(h_op_a), .op_b(h_op_b), .sub(h_sub), .tag_in(h_tag_in),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .flags(h_flags), .tag_out(h_tag_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
  } exp_t;

  vec_t vq[$];
  exp_t eq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic s, logic [31:0] r, logic [3:0] f);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.r = r; v.f = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", name, obs, exp);
  endtask

  task automatic run_op(input vec_t v, input logic [3:0] tag, input string name);
    int lat;
    @(negedge clk);
    op_a = v.a; op_b = v.b; sub = v.s; tag_in = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd3);
    check({name, " result"}, result, v.r);
    check({name, " flags"}, 32'(flags), 32'(v.f));
    check({name, " tag"}, 32'(tag_out), 32'(tag));
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                       input logic [3:0] f, input string name);
    int lat;
    @(negedge clk);
    h_op_a = a; h_op_b = b; h_sub = 1'b0; h_tag_in = 4'd9;
    h_in_valid = 1'b1; h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 1;
    while (!h_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd3);
    check({name, " result"}, 32'(h_result), 32'(r));
    check({name, " flags"}, 32'(h_flags), 32'(f));
  endtask

  initial begin
    int sent, got, cyc, idx, seen;
    bit holding;
    exp_t e;

    // a, b, sub, expected result, expected {NV,OF,UF,NX}
    vq.push_back(mk(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0));
    vq.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0));
    vq.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0));
    vq.push_back(mk(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1));
    vq.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1));
    vq.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5));
    vq.push_back(mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8));
    vq.push_back(mk(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8));
    vq.push_back(mk(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'h3));
    vq.push_back(mk(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0));
    vq.push_back(mk(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0));
    vq.push_back(mk(32'h3F800000, 32'h007FFFFF, 1'b0, 32'h3F800000, 4'h0));
    vq.push_back(mk(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'h0));
    vq.push_back(mk(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0));
    vq.push_back(mk(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0));
    vq.push_back(mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0));
    vq.push_back(mk(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1));
    vq.push_back(mk(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'h1));
    vq.push_back(mk(32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'h5));
    vq.push_back(mk(32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'h0));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
    op_a = '0; op_b = '0; tag_in = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_sub = 1'b0;
    h_op_a = '0; h_op_b = '0; h_tag_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset tag_out", 32'(tag_out), 32'd0);

    for (int i = 0; i < vq.size(); i++)
      run_op(vq[i], 4'(i + 5), $sformatf("vec%0d", i));

    run16(16'h3C00, 16'h3C00, 16'h4000, 4'h0, "fp16 one plus one");
    run16(16'h7BFF, 16'h7BFF, 16'h7C00, 4'h5, "fp16 overflow");

    // random valid/ready stream drawn from the directed table
    sent = 0; got = 0; cyc = 0; holding = 1'b0;
    while (got < 16 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!holding) begin
        if (sent < 16 && $urandom_range(0, 3) != 0) begin
          idx = int'($urandom_range(0, vq.size() - 1));
          op_a = vq[idx].a; op_b = vq[idx].b; sub = vq[idx].s;
          tag_in = 4'(sent);
          e.r = vq[idx].r; e.f = vq[idx].f; e.t = 4'(sent);
          in_valid = 1'b1;
          holding = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid) begin
        check("stream output expected", 32'(eq.size() != 0), 32'd1);
        if (eq.size() != 0) begin
          check("stream result", result, eq[0].r);
          check("stream flags", 32'(flags), 32'(eq[0].f));
          check("stream tag", 32'(tag_out), 32'(eq[0].t));
          if (out_ready) begin
            void'(eq.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        eq.push_back(e);
        sent++;
        holding = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream drained count", 32'(got), 32'd16);

    // fill the pipe under stall, then reset mid-flight
    @(negedge clk);
    out_ready = 1'b0;
    op_a = vq[0].a; op_b = vq[0].b; sub = vq[0].s; tag_in = 4'd3;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full in_ready", 32'(in_ready), 32'd0);
    check("full out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1 check("full drain in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no stale output", 32'(seen), 32'd0);
    run_op(vq[9], 4'd12, "post reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
